// File: rtl/bp_me_nonsynth_cce_inst_profiler.sv
// Multi-CCE instruction profiler for ME testbenches.
// Each channel keeps a ring-buffer history of executed {pc, inst} pairs,
// saturating per-major-op counters, and a sticky stall watchdog. A trigger
// freezes a channel's history a fixed number of captures later. State is
// read back through a registered read port. An optional text trace is
// printed per channel (simulation only, off by default).
module bp_me_nonsynth_cce_inst_profiler #(
  parameter int num_cce_p      = 2,
  parameter int cce_pc_width_p = 8,
  parameter int inst_width_p   = 48,
  parameter int op_lsb_p       = 0,
  parameter int depth_p        = 16,
  parameter int cnt_width_p    = 16,
  parameter int stall_thresh_p = 64,
  parameter int post_trig_p    = 4,
  parameter int trace_en_p     = 0,
  localparam int chan_w_lp     = (num_cce_p > 1) ? $clog2(num_cce_p) : 1,
  localparam int ptr_w_lp      = $clog2(depth_p),
  localparam int entry_w_lp    = cce_pc_width_p + inst_width_p
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_cce_p-1:0]                inst_v_i,
  input  logic [num_cce_p*cce_pc_width_p-1:0] fetch_pc_i,
  input  logic [num_cce_p*inst_width_p-1:0]   inst_i,
  input  logic                                trigger_i,
  input  logic                                clear_i,
  input  logic                                rd_v_i,
  input  logic                                rd_kind_i,
  input  logic [chan_w_lp-1:0]                rd_chan_i,
  input  logic [ptr_w_lp-1:0]                 rd_idx_i,
  output logic                                rd_v_o,
  output logic                                rd_hit_o,
  output logic [entry_w_lp-1:0]               rd_data_o,
  output logic [num_cce_p-1:0]                stall_o,
  output logic [num_cce_p-1:0]                frozen_o
);

  localparam int fill_w_lp = ptr_w_lp + 1;
  localparam int run_w_lp  = $clog2(stall_thresh_p + 1);
  localparam int rem_w_lp  = $clog2(depth_p + 1);

  typedef enum logic [1:0] {
    TRIG_IDLE,
    TRIG_ARMED,
    TRIG_FROZEN
  } trig_state_e;

  // Per-channel views of the packed input buses
  logic [cce_pc_width_p-1:0] ch_pc   [num_cce_p];
  logic [inst_width_p-1:0]   ch_inst [num_cce_p];
  logic [2:0]                ch_op   [num_cce_p];

  logic [ptr_w_lp-1:0]       wptr_q   [num_cce_p], wptr_d   [num_cce_p];
  logic [fill_w_lp-1:0]      fill_q   [num_cce_p], fill_d   [num_cce_p];
  logic [cnt_width_p-1:0]    cnt_q    [num_cce_p][8], cnt_d [num_cce_p][8];
  logic [run_w_lp-1:0]       run_q    [num_cce_p], run_d    [num_cce_p];
  logic [cce_pc_width_p-1:0] last_pc_q[num_cce_p], last_pc_d[num_cce_p];
  trig_state_e               state_q  [num_cce_p], state_d  [num_cce_p];
  logic [rem_w_lp-1:0]       remain_q [num_cce_p], remain_d [num_cce_p];
  logic [num_cce_p-1:0]      stall_q, stall_d;
  logic [num_cce_p-1:0]      cap_en;

  logic [entry_w_lp-1:0]     hist_mem [num_cce_p][depth_p];

  logic                      rd_v_q, rd_v_d;
  logic                      rd_hit_q, rd_hit_d;
  logic [entry_w_lp-1:0]     rd_data_q, rd_data_d;
  logic                      rd_chan_ok;
  logic [chan_w_lp-1:0]      rd_ch;
  logic [ptr_w_lp-1:0]       rd_addr;
  logic [2:0]                rd_op;

  // Slice the packed per-channel buses into arrays
  always_comb begin
    for (int c = 0; c < num_cce_p; c++) begin
      ch_pc[c]   = fetch_pc_i[c*cce_pc_width_p +: cce_pc_width_p];
      ch_inst[c] = inst_i[c*inst_width_p +: inst_width_p];
      ch_op[c]   = ch_inst[c][op_lsb_p +: 3];
    end
  end

  // Per-channel next state: capture, counters, watchdog, trigger FSM; clear wins
  // NOTE: every _d is given its hold value before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    stall_d = stall_q;
    for (int c = 0; c < num_cce_p; c++) begin
      wptr_d[c]    = wptr_q[c];
      fill_d[c]    = fill_q[c];
      run_d[c]     = run_q[c];
      last_pc_d[c] = last_pc_q[c];
      state_d[c]   = state_q[c];
      remain_d[c]  = remain_q[c];
      for (int op = 0; op < 8; op++) cnt_d[c][op] = cnt_q[c][op];
      cap_en[c] = inst_v_i[c] && (state_q[c] != TRIG_FROZEN) && !clear_i;

      if (clear_i) begin
        fill_d[c]   = '0;
        run_d[c]    = '0;
        stall_d[c]  = 1'b0;
        state_d[c]  = TRIG_IDLE;
        remain_d[c] = '0;
        for (int op = 0; op < 8; op++) cnt_d[c][op] = '0;
      end else begin
        if (cap_en[c]) begin
          wptr_d[c] = wptr_q[c] + ptr_w_lp'(1);
          if (fill_q[c] != fill_w_lp'(depth_p)) fill_d[c] = fill_q[c] + fill_w_lp'(1);
        end

        // Counters keep running while the history is frozen
        if (inst_v_i[c] && (cnt_q[c][ch_op[c]] != '1))
          cnt_d[c][ch_op[c]] = cnt_q[c][ch_op[c]] + cnt_width_p'(1);

        // Idle cycles and re-executions of the same PC both count as no progress
        if (!inst_v_i[c] || (ch_pc[c] == last_pc_q[c])) begin
          if (run_q[c] != run_w_lp'(stall_thresh_p)) run_d[c] = run_q[c] + run_w_lp'(1);
        end else begin
          run_d[c] = '0;
        end
        if (run_d[c] == run_w_lp'(stall_thresh_p)) stall_d[c] = 1'b1;
        if (inst_v_i[c]) last_pc_d[c] = ch_pc[c];

        unique case (state_q[c])
          TRIG_IDLE: begin
            if (trigger_i) begin
              if (post_trig_p == 0) begin
                state_d[c] = TRIG_FROZEN;
              end else begin
                state_d[c]  = TRIG_ARMED;
                remain_d[c] = rem_w_lp'(post_trig_p);
              end
            end
          end
          TRIG_ARMED: begin
            if (cap_en[c]) begin
              remain_d[c] = remain_q[c] - rem_w_lp'(1);
              if (remain_q[c] == rem_w_lp'(1)) state_d[c] = TRIG_FROZEN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-channel state registers
  // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_q <= '0;
      for (int c = 0; c < num_cce_p; c++) begin
        wptr_q[c]    <= '0;
        fill_q[c]    <= '0;
        run_q[c]     <= '0;
        last_pc_q[c] <= '0;
        state_q[c]   <= TRIG_IDLE;
        remain_q[c]  <= '0;
        for (int op = 0; op < 8; op++) cnt_q[c][op] <= '0;
      end
    end else begin
      stall_q <= stall_d;
      for (int c = 0; c < num_cce_p; c++) begin
        wptr_q[c]    <= wptr_d[c];
        fill_q[c]    <= fill_d[c];
        run_q[c]     <= run_d[c];
        last_pc_q[c] <= last_pc_d[c];
        state_q[c]   <= state_d[c];
        remain_q[c]  <= remain_d[c];
        for (int op = 0; op < 8; op++) cnt_q[c][op] <= cnt_d[c][op];
      end
    end
  end

  // History ring write
  // NOTE: the history array has no reset; entries beyond the fill count are never returned.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_cce_p; c++) begin
      if (cap_en[c]) hist_mem[c][wptr_q[c]] <= {ch_pc[c], ch_inst[c]};
    end
  end

  // Read lookup on pre-update state; data holds when no read is issued
  always_comb begin
    rd_chan_ok = (32'(rd_chan_i) < num_cce_p);
    rd_ch      = rd_chan_ok ? rd_chan_i : '0;
    rd_addr    = wptr_q[rd_ch] - ptr_w_lp'(1) - rd_idx_i;
    rd_op      = 3'(rd_idx_i);
    rd_v_d     = rd_v_i;
    rd_hit_d   = rd_hit_q;
    rd_data_d  = rd_data_q;
    if (rd_v_i) begin
      rd_hit_d  = 1'b0;
      rd_data_d = '0;
      if (rd_chan_ok) begin
        if (rd_kind_i) begin
          rd_hit_d  = 1'b1;
          rd_data_d = entry_w_lp'(cnt_q[rd_ch][rd_op]);
        end else if ({1'b0, rd_idx_i} < fill_q[rd_ch]) begin
          rd_hit_d  = 1'b1;
          rd_data_d = hist_mem[rd_ch][rd_addr];
        end
      end
    end
  end

  // Read response registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_v_q    <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_v_q    <= rd_v_d;
      rd_hit_q  <= rd_hit_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Output mapping
  always_comb begin
    rd_v_o    = rd_v_q;
    rd_hit_o  = rd_hit_q;
    rd_data_o = rd_data_q;
    stall_o   = stall_q;
    for (int c = 0; c < num_cce_p; c++) frozen_o[c] = (state_q[c] == TRIG_FROZEN);
  end

  if (trace_en_p != 0) begin : g_trace
    function automatic string op_name(input logic [2:0] op);
      case (op)
        3'd0:    return "alu";
        3'd1:    return "branch";
        3'd2:    return "reg_data";
        3'd3:    return "flag";
        3'd4:    return "dir";
        3'd5:    return "queue";
        default: return "invalid";
      endcase
    endfunction

    // Log executed instructions on the falling edge, away from capture
    always @(negedge clk_i) begin
      if (reset_i) begin
        for (int c = 0; c < num_cce_p; c++) begin
          if (inst_v_i[c])
            $display("cce_prof_%0d.trace: %0t,%h,%s,%h%s", c, $time, ch_pc[c],
                     op_name(ch_op[c]), ch_inst[c],
                     (state_q[c] == TRIG_FROZEN) ? " FROZEN" : "");
        end
      end
    end
  end

endmodule
